// File: rtl/ysyx_22050058_ifu_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050058_ifu_pkg
// Shared constants for the instruction fetch unit: bus widths, the zero
// word, chip-enable levels and the IFU state encodings.
// ---------------------------------------------------------------------------
package ysyx_22050058_ifu_pkg;

   localparam int INST_ADDR_W = 32;   // byte address bus width
   localparam int INST_W      = 32;   // instruction bus width

   localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   // IFU state encodings
   localparam logic [1:0] IFU_IDLE  = 2'd0;
   localparam logic [1:0] IFU_FETCH = 2'd1;
   localparam logic [1:0] IFU_HALT  = 2'd2;
   localparam logic [1:0] IFU_ERR   = 2'd3;

endpackage

// File: rtl/ysyx_22050058_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_22050058_ifu
// Instruction fetch unit. Holds the PC, reads the combinational instruction
// ROM and presents one instruction at a time to decode over a valid/ready
// handshake. Supports redirects, a halt request and a sticky error on a
// misaligned redirect target.
//
// Ports
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   rom_ce         : ROM chip enable (asserted on a fetch cycle)
//   rom_addr       : ROM byte address (= PC)
//   rom_inst       : ROM read data, same cycle as rom_addr
//   redirect_valid : redirect request (branch/jump/trap)
//   redirect_pc    : redirect target
//   halt           : stop fetching
//   out_valid      : instruction held for decode
//   out_ready      : decode accepts the held instruction
//   out_pc         : PC of the held instruction
//   out_inst       : the held instruction
//   fetch_err      : sticky misaligned-redirect flag
//   fetch_cnt      : count of instructions handed to decode
// ---------------------------------------------------------------------------
module ysyx_22050058_ifu
   import ysyx_22050058_ifu_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   rom_ce,
   output logic [INST_ADDR_W-1:0] rom_addr,
   input  logic [INST_W-1:0]      rom_inst,
   input  logic                   redirect_valid,
   input  logic [INST_ADDR_W-1:0] redirect_pc,
   input  logic                   halt,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [INST_ADDR_W-1:0] out_pc,
   output logic [INST_W-1:0]      out_inst,
   output logic                   fetch_err,
   output logic [31:0]            fetch_cnt
);

   logic [1:0]             r_state;
   logic [INST_ADDR_W-1:0] r_pc;
   logic                   r_out_valid;
   logic [INST_ADDR_W-1:0] r_out_pc;
   logic [INST_W-1:0]      r_out_inst;
   logic                   r_fetch_err;
   logic [31:0]            r_fetch_cnt;

   logic w_fetch;
   logic w_handshake;

   // A fetch happens only when the output slot is free or being drained this
   // cycle; redirect and halt both suppress it.
   assign w_fetch = !rst && (r_state == IFU_FETCH) && !redirect_valid && !halt &&
                    (!r_out_valid || out_ready);
   assign w_handshake = r_out_valid && out_ready;

   assign rom_ce    = w_fetch ? CHIP_ENABLE : CHIP_DISABLE;
   assign rom_addr  = r_pc;
   assign out_valid = r_out_valid;
   assign out_pc    = r_out_pc;
   assign out_inst  = r_out_inst;
   assign fetch_err = r_fetch_err;
   assign fetch_cnt = r_fetch_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IFU_IDLE;
         r_pc        <= RESET_PC;
         r_out_valid <= 1'b0;
         r_out_pc    <= '0;
         r_out_inst  <= ZERO_WORD;
         r_fetch_err <= 1'b0;
         r_fetch_cnt <= '0;
      end else begin
         // A handshake is counted in every state, including when a redirect
         // or halt lands in the same cycle.
         if (w_handshake) r_fetch_cnt <= r_fetch_cnt + 32'd1;

         case (r_state)
            IFU_IDLE: r_state <= IFU_FETCH;

            IFU_FETCH: begin
               if (redirect_valid) begin
                  r_out_valid <= 1'b0;
                  if (redirect_pc[1:0] != 2'b00) begin
                     r_state     <= IFU_ERR;
                     r_fetch_err <= 1'b1;
                  end else begin
                     r_pc <= redirect_pc;
                  end
               end else if (halt) begin
                  // Held instruction survives until decode takes it.
                  r_state <= IFU_HALT;
                  if (w_handshake) r_out_valid <= 1'b0;
               end else if (w_fetch) begin
                  r_out_valid <= 1'b1;
                  r_out_pc    <= r_pc;
                  r_out_inst  <= rom_inst;
                  r_pc        <= r_pc + 32'd4;
               end else if (w_handshake) begin
                  r_out_valid <= 1'b0;
               end
            end

            IFU_HALT: begin
               if (w_handshake) r_out_valid <= 1'b0;
            end

            default: ;   // ERR: frozen until reset
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_22050058_ifu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050058_ifu
// Directed bench for the fetch unit. The ROM is modelled as a fixed function
// of the address so that out_inst can be predicted from out_pc.
// ---------------------------------------------------------------------------
module tb_ysyx_22050058_ifu;

   logic        clk;
   logic        rst;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic [31:0] rom_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   int n_chk;
   int n_pass;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   assign rom_inst = rom_f(rom_addr);

   ysyx_22050058_ifu #(.RESET_PC(32'h8000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .rom_ce         (rom_ce),
      .rom_addr       (rom_addr),
      .rom_inst       (rom_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .fetch_err      (fetch_err),
      .fetch_cnt      (fetch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, act, exp);
   endtask

   // Advance one edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
      chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
      chk({tag, ".pc"}, out_pc, pc);
      chk({tag, ".inst"}, out_inst, rom_f(pc));
      chk({tag, ".cnt"}, fetch_cnt, cnt);
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      halt = 1'b0;
      out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst.valid", {31'd0, out_valid}, 32'd0);
      chk("rst.pc", out_pc, 32'd0);
      chk("rst.inst", out_inst, 32'd0);
      chk("rst.err", {31'd0, fetch_err}, 32'd0);
      chk("rst.cnt", fetch_cnt, 32'd0);
      chk("rst.ce", {31'd0, rom_ce}, 32'd0);
      rst = 1'b0;
      #1;
      chk("idle.ce", {31'd0, rom_ce}, 32'd0);

      // Streaming with out_ready held high
      tick();
      chk("fetch0.ce", {31'd0, rom_ce}, 32'd1);
      chk("fetch0.addr", rom_addr, 32'h8000_0000);
      tick();
      chk_out("s0", 32'h8000_0000, 32'd0);
      tick();
      chk_out("s1", 32'h8000_0004, 32'd1);

      // Stall three cycles on 8000_0004
      out_ready = 1'b0;
      #1;
      chk("stall.ce", {31'd0, rom_ce}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("stall", 32'h8000_0004, 32'd1);
         chk("stall.ce2", {31'd0, rom_ce}, 32'd0);
      end

      // Redirect while stalled
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0100;
      tick();
      chk("redir.valid", {31'd0, out_valid}, 32'd0);
      chk("redir.cnt", fetch_cnt, 32'd1);
      redirect_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("redir.addr", rom_addr, 32'h8000_0100);
      chk("redir.ce", {31'd0, rom_ce}, 32'd1);
      tick();
      chk_out("redir.t0", 32'h8000_0100, 32'd1);
      tick();
      chk_out("redir.t1", 32'h8000_0104, 32'd2);

      // Halt with a held instruction
      out_ready = 1'b0;
      halt = 1'b1;
      #1;
      chk("halt.ce", {31'd0, rom_ce}, 32'd0);
      tick();
      chk_out("halt.h0", 32'h8000_0104, 32'd2);
      halt = 1'b0;
      tick();
      chk_out("halt.h1", 32'h8000_0104, 32'd2);
      out_ready = 1'b1;
      tick();
      chk("halt.drain.valid", {31'd0, out_valid}, 32'd0);
      chk("halt.drain.cnt", fetch_cnt, 32'd3);
      chk("halt.drain.ce", {31'd0, rom_ce}, 32'd0);
      tick();
      chk("halt.stay.ce", {31'd0, rom_ce}, 32'd0);
      chk("halt.stay.valid", {31'd0, out_valid}, 32'd0);

      // Reset out of HALT, stream to pc = 8000_0010, then reset mid-stream
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst2.valid", {31'd0, out_valid}, 32'd0);
      chk("rst2.cnt", fetch_cnt, 32'd0);
      tick();
      tick();
      chk_out("r2.s0", 32'h8000_0000, 32'd0);
      tick();
      tick();
      tick();
      chk_out("r2.s3", 32'h8000_000C, 32'd3);
      chk("r2.addr", rom_addr, 32'h8000_0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst3.valid", {31'd0, out_valid}, 32'd0);
      chk("rst3.cnt", fetch_cnt, 32'd0);
      chk("rst3.pc", out_pc, 32'd0);
      tick();
      tick();
      chk_out("r3.s0", 32'h8000_0000, 32'd0);
      tick();
      chk_out("r3.s1", 32'h8000_0004, 32'd1);

      // Redirect + halt + ready together: count handshake, take redirect
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0200;
      halt = 1'b1;
      tick();
      chk("mix.valid", {31'd0, out_valid}, 32'd0);
      chk("mix.cnt", fetch_cnt, 32'd2);
      redirect_valid = 1'b0;
      halt = 1'b0;
      #1;
      chk("mix.ce", {31'd0, rom_ce}, 32'd1);
      tick();
      chk_out("mix.t0", 32'h8000_0200, 32'd2);
      tick();
      chk_out("mix.t1", 32'h8000_0204, 32'd3);

      // PC wrap from FFFF_FFFC to 0
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      tick();
      redirect_valid = 1'b0;
      chk("wrap.cnt", fetch_cnt, 32'd4);
      tick();
      chk_out("wrap.w0", 32'hFFFF_FFF8, 32'd4);
      tick();
      chk_out("wrap.w1", 32'hFFFF_FFFC, 32'd5);
      tick();
      chk_out("wrap.w2", 32'h0000_0000, 32'd6);

      // Misaligned redirect -> sticky ERR
      redirect_valid = 1'b1;
      redirect_pc = 32'h8000_0102;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("err.flag", {31'd0, fetch_err}, 32'd1);
      chk("err.valid", {31'd0, out_valid}, 32'd0);
      chk("err.cnt", fetch_cnt, 32'd7);
      for (int i = 0; i < 3; i++) begin
         chk("err.ce", {31'd0, rom_ce}, 32'd0);
         tick();
      end
      chk("err.sticky", {31'd0, fetch_err}, 32'd1);
      chk("err.valid2", {31'd0, out_valid}, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("err.clr", {31'd0, fetch_err}, 32'd0);
      tick();
      tick();
      chk_out("err.rec", 32'h8000_0000, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
